bmp_pixel_stream: RTL and testbench
===================================

Name: bmp_pixel_stream

Overview:
- Downstream consumer of the BMP loader; starts once the loader's done is high and the whole BMP file sits in byte-wide RAM.
- Reads and validates the 54-byte BMP header from RAM and exposes width, height and pixel-data offset.
- Then streams the pixel-array bytes, in address order, to the next processing stage over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 16: RAM byte-address width.
- BYTE_WIDTH, 8: RAM/pixel data width.
- MAX_SIZE, 65535: largest legal file size in bytes, per the header file-size field.
- HDR_SIZE, 54: header length in bytes; minimum legal data offset.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1).
- start  in  1  one-cycle request to begin; sampled only in IDLE, DONE or ERR.
- RAM_Q  in  BYTE_WIDTH  RAM read data; valid the cycle after RAM_valid.
- RAM_valid  out  1  RAM read enable for RAM_addr.
- RAM_addr  out  ADDR_WIDTH  RAM byte address.
- pix_valid  out  1  pix_data holds a valid byte.
- pix_ready  in  1  downstream accepts the byte; a transfer occurs when pix_valid && pix_ready.
- pix_data  out  BYTE_WIDTH  pixel byte.
- img_width  out  32  header bytes 18-21, little-endian.
- img_height  out  32  header bytes 22-25, little-endian.
- data_offset  out  32  header bytes 10-13, little-endian.
- busy  out  1  high in every state except IDLE, DONE and ERR.
- done  out  1  level; high in DONE.
- hdr_err  out  1  level; high in ERR.

Behaviour:
- Reset: state IDLE. All outputs 0, including RAM_addr, pix_data, the header fields and the byte/pixel counters. Reset mid-operation aborts immediately, with no partial-output guarantee.
- States: IDLE, HDR_REQ, HDR_CAP, CHECK, PIX_REQ, PIX_CAP, PIX_OUT, DONE, ERR.
- IDLE/DONE/ERR + start:
  - go to HDR_REQ; clear the header fields, done and hdr_err; set the byte counter k=0.
  - start in any other state is ignored.
- HDR_REQ: RAM_valid=1, RAM_addr=k. Next state HDR_CAP.
- HDR_CAP: capture RAM_Q into header byte k.
  - Bytes 0-1 are the signature; bytes 2-5 the file size; 10-13 the offset; 18-21 the width; 22-25 the height; 28-29 the bpp (all little-endian).
  - k==HDR_SIZE-1 → CHECK; else k++ and → HDR_REQ.
  - The header read therefore takes exactly 2*HDR_SIZE = 108 cycles.
- CHECK (1 cycle): go to ERR if any of the following holds, otherwise go to PIX_REQ with p=data_offset:
  - signature != 0x42,0x4D;
  - bpp != 24;
  - offset < HDR_SIZE;
  - offset >= file size;
  - file size > MAX_SIZE.
- PIX_REQ: RAM_valid=1, RAM_addr=p. Next state PIX_CAP.
- PIX_CAP: pix_data<=RAM_Q, pix_valid<=1. Next state PIX_OUT.
- PIX_OUT: hold pix_valid and pix_data stable until pix_ready.
  - On transfer, pix_valid drops the next cycle.
  - If p==filesize-1 → DONE; else p++ and → PIX_REQ.
- Throughput: at most 1 byte per 3 cycles. With pix_ready tied high, each byte takes exactly 3 cycles.
- Ordering: no byte is skipped or repeated. The total transferred equals filesize-data_offset.
- RAM_valid is never high outside HDR_REQ and PIX_REQ.
- Address arithmetic: addresses are formed from the low ADDR_WIDTH bits of p. The MAX_SIZE check guarantees there is no wrap.
- Header outputs: updated byte-wise during HDR_CAP. They are stable from CHECK until the next start, and remain readable in DONE and ERR.
- DONE/ERR: pix_valid=0, RAM_valid=0. The block waits for start.

Test Plan:
- Valid 4x2 24-bit BMP (file size 78, offset 54), pix_ready=1 → img_width=4, img_height=2, data_offset=54; exactly 24 transfers with bytes equal to RAM[54..77] in order; done high 72 cycles after entering PIX_REQ; hdr_err=0.
- Same image, pix_ready toggling 1-of-3 cycles → same 24 bytes in order; pix_data held stable while pix_valid && !pix_ready.
- Signature 0x42,0x4E → ERR after 109 cycles; no pix_valid; hdr_err=1, done=0.
- bpp=8 → hdr_err=1; offset=54 with file size 54 → hdr_err=1.
- Reset asserted during PIX_OUT → all outputs 0 asynchronously; a following start re-reads the header from address 0 and streams the full image.
- start pulsed while busy → ignored (no restart, identical output); start in DONE → full second pass with identical results.

Source files
------------

// File: rtl/bmp_pixel_stream_if.sv
// rtl/bmp_pixel_stream_if.sv - RAM read port and pixel stream handshake bundle
interface bmp_pixel_stream_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int BYTE_WIDTH = 8
);
   logic                  RAM_valid;
   logic [ADDR_WIDTH-1:0] RAM_addr;
   logic [BYTE_WIDTH-1:0] RAM_Q;
   logic                  pix_valid;
   logic                  pix_ready;
   logic [BYTE_WIDTH-1:0] pix_data;

   modport master (
      output RAM_valid, RAM_addr,
      input  RAM_Q,
      output pix_valid, pix_data,
      input  pix_ready
   );

   modport slave (
      input  RAM_valid, RAM_addr,
      output RAM_Q,
      input  pix_valid, pix_data,
      output pix_ready
   );
endinterface

// File: rtl/bmp_pixel_stream.sv
// rtl/bmp_pixel_stream.sv - BMP header validation and pixel byte streamer
module bmp_pixel_stream #(
   parameter int ADDR_WIDTH = 16,
   parameter int BYTE_WIDTH = 8,
   parameter int MAX_SIZE   = 65535,
   parameter int HDR_SIZE   = 54
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   bmp_pixel_stream_if.master  bus,
   output logic [31:0]         img_width,
   output logic [31:0]         img_height,
   output logic [31:0]         data_offset,
   output logic                busy,
   output logic                done,
   output logic                hdr_err
);

   localparam int             K_W    = $clog2(HDR_SIZE);
   localparam logic [K_W-1:0] K_LAST = K_W'(HDR_SIZE - 1);

   typedef enum logic [3:0] {
      IDLE, HDR_REQ, HDR_CAP, CHECK, PIX_REQ, PIX_CAP, PIX_OUT, DONE, ERR
   } state_t;

   state_t                state;
   logic [K_W-1:0]        k;
   logic [K_W-1:0]        k_inc;
   logic [31:0]           p;
   logic [31:0]           p_inc;
   logic [31:0]           file_size;
   logic [15:0]           signature;
   logic [15:0]           bpp;
   logic [BYTE_WIDTH-1:0] q;
   logic [7:0]            hb;
   logic                  hdr_bad;

   assign q     = bus.RAM_Q;
   assign hb    = q[7:0];
   assign k_inc = k + K_W'(1);
   assign p_inc = p + 32'd1;
   assign busy  = !(state == IDLE || state == DONE || state == ERR);

   // Header legality rules evaluated from the captured fields; the size cap also rules out address wrap
   always_comb begin
      hdr_bad = (signature != 16'h4D42) ||
                (bpp != 16'd24) ||
                (data_offset < 32'(HDR_SIZE)) ||
                (data_offset >= file_size) ||
                (file_size > 32'(MAX_SIZE));
   end

   // Main sequencer: outputs are registered and set on the transition into the state that owns them
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state         <= IDLE;
         k             <= '0;
         p             <= '0;
         file_size     <= '0;
         signature     <= '0;
         bpp           <= '0;
         img_width     <= '0;
         img_height    <= '0;
         data_offset   <= '0;
         done          <= 1'b0;
         hdr_err       <= 1'b0;
         bus.RAM_valid <= 1'b0;
         bus.RAM_addr  <= '0;
         bus.pix_valid <= 1'b0;
         bus.pix_data  <= '0;
      end else begin
         unique case (state)
            IDLE, DONE, ERR: begin
               bus.RAM_valid <= 1'b0;
               bus.pix_valid <= 1'b0;
               if (start) begin
                  k             <= '0;
                  file_size     <= '0;
                  signature     <= '0;
                  bpp           <= '0;
                  img_width     <= '0;
                  img_height    <= '0;
                  data_offset   <= '0;
                  done          <= 1'b0;
                  hdr_err       <= 1'b0;
                  bus.RAM_valid <= 1'b1;
                  bus.RAM_addr  <= '0;
                  state         <= HDR_REQ;
               end
            end
            HDR_REQ: begin
               bus.RAM_valid <= 1'b0;
               state         <= HDR_CAP;
            end
            HDR_CAP: begin
               case (k)
                  K_W'(0):  signature[7:0]    <= hb;
                  K_W'(1):  signature[15:8]   <= hb;
                  K_W'(2):  file_size[7:0]    <= hb;
                  K_W'(3):  file_size[15:8]   <= hb;
                  K_W'(4):  file_size[23:16]  <= hb;
                  K_W'(5):  file_size[31:24]  <= hb;
                  K_W'(10): data_offset[7:0]   <= hb;
                  K_W'(11): data_offset[15:8]  <= hb;
                  K_W'(12): data_offset[23:16] <= hb;
                  K_W'(13): data_offset[31:24] <= hb;
                  K_W'(18): img_width[7:0]    <= hb;
                  K_W'(19): img_width[15:8]   <= hb;
                  K_W'(20): img_width[23:16]  <= hb;
                  K_W'(21): img_width[31:24]  <= hb;
                  K_W'(22): img_height[7:0]   <= hb;
                  K_W'(23): img_height[15:8]  <= hb;
                  K_W'(24): img_height[23:16] <= hb;
                  K_W'(25): img_height[31:24] <= hb;
                  K_W'(28): bpp[7:0]          <= hb;
                  K_W'(29): bpp[15:8]         <= hb;
                  default: ;
               endcase
               if (k == K_LAST) begin
                  state <= CHECK;
               end else begin
                  k             <= k_inc;
                  bus.RAM_valid <= 1'b1;
                  bus.RAM_addr  <= ADDR_WIDTH'(k_inc);
                  state         <= HDR_REQ;
               end
            end
            CHECK: begin
               if (hdr_bad) begin
                  hdr_err <= 1'b1;
                  state   <= ERR;
               end else begin
                  p             <= data_offset;
                  bus.RAM_valid <= 1'b1;
                  bus.RAM_addr  <= data_offset[ADDR_WIDTH-1:0];
                  state         <= PIX_REQ;
               end
            end
            PIX_REQ: begin
               bus.RAM_valid <= 1'b0;
               state         <= PIX_CAP;
            end
            PIX_CAP: begin
               bus.pix_data  <= q;
               bus.pix_valid <= 1'b1;
               state         <= PIX_OUT;
            end
            PIX_OUT: begin
               if (bus.pix_ready) begin
                  bus.pix_valid <= 1'b0;
                  if (p == file_size - 32'd1) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     p             <= p_inc;
                     bus.RAM_valid <= 1'b1;
                     bus.RAM_addr  <= p_inc[ADDR_WIDTH-1:0];
                     state         <= PIX_REQ;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bmp_pixel_stream.sv
// tb/tb_bmp_pixel_stream.sv - randomized self-checking bench with behavioural BMP model
module tb_bmp_pixel_stream;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic [31:0] img_width, img_height, data_offset;
   logic        busy, done, hdr_err;

   bmp_pixel_stream_if #(.ADDR_WIDTH(16), .BYTE_WIDTH(8)) bus ();

   bmp_pixel_stream #(
      .ADDR_WIDTH(16), .BYTE_WIDTH(8), .MAX_SIZE(65535), .HDR_SIZE(54)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
      .img_width(img_width), .img_height(img_height), .data_offset(data_offset),
      .busy(busy), .done(done), .hdr_err(hdr_err)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [0:65535];

   // byte-wide RAM with one-cycle read latency
   always @(posedge clk) begin
      if (bus.RAM_valid) bus.RAM_Q <= mem[bus.RAM_addr];
   end

   int          checks = 0;
   int          fails  = 0;
   int          ready_mode = 0;
   int          rc = 0;
   int unsigned exp_addr[$];
   logic [7:0]  exp_pix[$];
   int          n_xfer = 0;
   bit          held = 1'b0;
   logic [7:0]  held_data;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int unsigned rd32(input int a);
      return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
   endfunction

   task automatic set32(input int a, input int unsigned v);
      for (int i = 0; i < 4; i++) mem[a+i] = v[8*i +: 8];
   endtask

   // header legality as the reference sees it, read straight from the file bytes
   function automatic bit model_err();
      int unsigned fs, off, bp;
      fs  = rd32(2);
      off = rd32(10);
      bp  = {16'd0, mem[29], mem[28]};
      return (mem[0] != 8'h42) || (mem[1] != 8'h4D) || (bp != 24) ||
             (off < 54) || (off >= fs) || (fs > 65535);
   endfunction

   task automatic make_image(input int w, input int h, input int off, input logic [7:0] sig1, input int bp);
      int fs;
      fs = off + 3 * w * h;
      for (int i = 0; i < fs; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h42;
      mem[1] = sig1;
      set32(2, fs);
      set32(10, off);
      set32(18, w);
      set32(22, h);
      mem[28] = 8'(bp);
      mem[29] = 8'(bp >> 8);
   endtask

   // downstream ready pattern, changed just after each rising edge
   initial begin
      bus.pix_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: bus.pix_ready = 1'b1;
            1: bus.pix_ready = (rc % 3 == 0);
            default: bus.pix_ready = 1'($urandom_range(0, 1));
         endcase
         rc++;
      end
   end

   // per-cycle compare against the model queues, sampled on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            if (bus.RAM_valid) begin
               if (exp_addr.size() == 0) chk("ram_read_unexpected", {48'd0, bus.RAM_addr}, 64'hFFFF_FFFF);
               else chk("ram_addr", {48'd0, bus.RAM_addr}, {32'd0, exp_addr.pop_front()});
            end
            if (bus.pix_valid) begin
               if (held) chk("pix_data_stable", {56'd0, bus.pix_data}, {56'd0, held_data});
               if (bus.pix_ready) begin
                  if (exp_pix.size() == 0) chk("pix_unexpected", {56'd0, bus.pix_data}, 64'hFFFF);
                  else chk("pix_data", {56'd0, bus.pix_data}, {56'd0, exp_pix.pop_front()});
                  n_xfer++;
                  held = 1'b0;
               end else begin
                  held      = 1'b1;
                  held_data = bus.pix_data;
               end
            end else begin
               if (held) chk("pix_valid_dropped_early", 64'd0, 64'd1);
               held = 1'b0;
            end
         end
      end
   end

   task automatic check_all_zero(input string nm);
      chk({nm, "_ram_valid"}, {63'd0, bus.RAM_valid}, 64'd0);
      chk({nm, "_ram_addr"}, {48'd0, bus.RAM_addr}, 64'd0);
      chk({nm, "_pix_valid"}, {63'd0, bus.pix_valid}, 64'd0);
      chk({nm, "_pix_data"}, {56'd0, bus.pix_data}, 64'd0);
      chk({nm, "_width"}, {32'd0, img_width}, 64'd0);
      chk({nm, "_height"}, {32'd0, img_height}, 64'd0);
      chk({nm, "_offset"}, {32'd0, data_offset}, 64'd0);
      chk({nm, "_flags"}, {61'd0, busy, done, hdr_err}, 64'd0);
   endtask

   // exp_err_lit / exp_cyc_lit: -1 leaves that aspect to the model alone
   task automatic run_image(input string nm, input int mode, input int exp_err_lit,
                            input int exp_cyc_lit, input bit poke, input bit abort);
      bit          err;
      int unsigned fs, off;
      int          cyc;
      int          exp_cyc;
      err = model_err();
      fs  = rd32(2);
      off = rd32(10);
      if (exp_err_lit >= 0) chk({nm, "_model_err"}, {63'd0, err}, 64'(exp_err_lit));
      exp_addr.delete();
      exp_pix.delete();
      for (int i = 0; i < 54; i++) exp_addr.push_back(i);
      if (!err) begin
         for (int unsigned a = off; a < fs; a++) begin
            exp_addr.push_back(a);
            exp_pix.push_back(mem[a]);
         end
      end
      n_xfer     = 0;
      held       = 1'b0;
      ready_mode = mode;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      cyc = 0;
      while (!(done || hdr_err) && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
         if (poke) start = (cyc == 150);
         if (abort && bus.pix_valid) begin
            @(negedge clk); #2;
            rst_n = 1'b1;
            #1;
            check_all_zero({nm, "_async_rst"});
            exp_addr.delete();
            exp_pix.delete();
            held = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b0;
            return;
         end
      end
      start = 1'b0;
      if (abort) chk({nm, "_reached_pixels"}, 64'd0, 64'd1);
      chk({nm, "_timeout"}, {63'd0, cyc >= 20000}, 64'd0);
      chk({nm, "_done"}, {63'd0, done}, {63'd0, !err});
      chk({nm, "_hdr_err"}, {63'd0, hdr_err}, {63'd0, err});
      chk({nm, "_busy_end"}, {63'd0, busy}, 64'd0);
      chk({nm, "_width"}, {32'd0, img_width}, {32'd0, rd32(18)});
      chk({nm, "_height"}, {32'd0, img_height}, {32'd0, rd32(22)});
      chk({nm, "_offset"}, {32'd0, data_offset}, {32'd0, off});
      chk({nm, "_xfers"}, 64'(n_xfer), err ? 64'd0 : 64'(fs - off));
      chk({nm, "_leftover"}, 64'(exp_addr.size() + exp_pix.size()), 64'd0);
      if (mode == 0) begin
         exp_cyc = err ? 109 : 109 + 3 * int'(fs - off);
         chk({nm, "_cycles"}, 64'(cyc), 64'(exp_cyc));
      end
      if (exp_cyc_lit >= 0) chk({nm, "_cycles_lit"}, 64'(cyc), 64'(exp_cyc_lit));
   endtask

   initial begin
      bus.RAM_Q = '0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n = 1'b0;

      make_image(4, 2, 54, 8'h4D, 24);
      run_image("img4x2", 0, 0, 181, 1'b0, 1'b0);
      chk("img4x2_width_lit", {32'd0, img_width}, 64'd4);
      chk("img4x2_height_lit", {32'd0, img_height}, 64'd2);
      chk("img4x2_offset_lit", {32'd0, data_offset}, 64'd54);
      chk("img4x2_xfers_lit", 64'(n_xfer), 64'd24);

      run_image("img4x2_stall", 1, 0, -1, 1'b0, 1'b0);
      run_image("img4x2_poke", 0, 0, 181, 1'b1, 1'b0);
      run_image("img4x2_again", 0, 0, 181, 1'b0, 1'b0);

      make_image(4, 2, 54, 8'h4E, 24);
      run_image("bad_sig", 0, 1, 109, 1'b0, 1'b0);
      make_image(4, 2, 54, 8'h4D, 8);
      run_image("bad_bpp", 0, 1, 109, 1'b0, 1'b0);
      make_image(4, 2, 54, 8'h4D, 24);
      set32(2, 54);
      run_image("off_eq_size", 0, 1, -1, 1'b0, 1'b0);
      make_image(4, 2, 40, 8'h4D, 24);
      run_image("off_small", 0, 1, -1, 1'b0, 1'b0);
      make_image(4, 2, 54, 8'h4D, 24);
      set32(2, 70000);
      run_image("size_big", 0, 1, -1, 1'b0, 1'b0);

      make_image(4, 2, 54, 8'h4D, 24);
      run_image("abort", 1, 0, -1, 1'b0, 1'b1);
      run_image("after_abort", 0, 0, 181, 1'b0, 1'b0);

      for (int t = 0; t < 8; t++) begin
         make_image($urandom_range(1, 6), $urandom_range(1, 4), 54 + $urandom_range(0, 10),
                    8'h4D, 24);
         if ($urandom_range(0, 3) == 0) mem[28] = 8'($urandom_range(0, 32));
         run_image($sformatf("rand%0d", t), t % 3, -1, -1, 1'b0, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", checks, fails);
      $finish;
   end

endmodule
